system_0_sysid_checker: RTL and testbench
=========================================

# system_0_sysid_checker

Avalon-MM read initiator that interrogates the system-ID control slave at boot or on request. It reads the ID word (address 0) and the timestamp word (address 1), compares both against build-time expected values, and reports pass/fail/timeout to the reset/boot sequencer. It sits on the system interconnect as a master port alongside the ID slave and guards against loading software onto a mismatched hardware image.

## Interface
- EXPECTED_ID, 32'h0000_0000, value the ID word (address 0) must return
- EXPECTED_TS, 32'd1766031671 (32'h6943_8137), value the timestamp word (address 1) must return
- READ_LATENCY, 0, fixed slave read latency in cycles after command acceptance; legal range 0..7
- TIMEOUT_CYCLES, 255, per-transaction cycle budget from read assertion to data capture; legal range 1..65535
- AUTO_START, 1, 1 = start one check automatically on the first cycle after reset release

- clock  input  1  system clock, all logic rising-edge
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  single-cycle request to run a check; ignored while busy
- avm_address  output  1  word address: 0 = ID, 1 = timestamp
- avm_read  output  1  read command
- avm_waitrequest  input  1  slave stall; tie to 0 for slaves with no stall
- avm_readdata  input  32  read data, valid READ_LATENCY cycles after acceptance
- busy  output  1  check in progress
- done  output  1  one-cycle pulse when a check finishes (pass, fail or timeout)
- id_ok  output  1  captured ID equals EXPECTED_ID; held until next start
- ts_ok  output  1  captured timestamp equals EXPECTED_TS; held until next start
- timeout  output  1  a transaction exceeded TIMEOUT_CYCLES; held until next start
- id_value  output  32  last captured ID word
- ts_value  output  32  last captured timestamp word

## Operation
- FSM states: IDLE, RD_ID, WAIT_ID, RD_TS, WAIT_TS, DONE.
- IDLE: on start (or the AUTO_START trigger), clear id_ok/ts_ok/timeout and go to RD_ID. id_value/ts_value are not cleared.
- RD_x: drive avm_read=1 with the matching address. Hold both stable while avm_waitrequest=1. Acceptance = avm_read & !avm_waitrequest.
- On acceptance with READ_LATENCY=0: capture avm_readdata on the same edge and advance (RD_ID->RD_TS, RD_TS->DONE).
- On acceptance with READ_LATENCY>0: go to WAIT_x with avm_read=0, count READ_LATENCY cycles, capture on the last one, then advance.
- Compare: id_ok/ts_ok are registered at capture from a full 32-bit equality.
- Timeout: a 16-bit counter resets at entry to each RD_x and increments every cycle in RD_x/WAIT_x. When it reaches TIMEOUT_CYCLES before capture: avm_read=0, timeout=1, remaining reads are skipped, go to DONE. The corresponding ok flag stays 0.
- DONE: done=1 for exactly one cycle, then IDLE.
- start in any non-IDLE state is ignored; it is not queued.
- The AUTO_START trigger fires once per reset release.

## Timing
- Reset: all outputs 0; FSM in IDLE; counters 0; id_value/ts_value 0.
- Reset asserted mid-transaction forces avm_read=0 immediately (asynchronous). The check restarts only via AUTO_START or start.
- Best case (READ_LATENCY=0, no stalls): start sampled at edge N; avm_read high in cycles N+1 (address 0) and N+2 (address 1); done and results valid in cycle N+3.
- General latency = 3 + 2·READ_LATENCY + total stall cycles.
- busy = 1 from the cycle after start through the DONE cycle inclusive.
- avm_address is a registered output and changes only at state transitions.

## Structure
- Shared package system_0_sysid_pkg holds the FSM state encoding, SYSID_ADDR_ID=1'b0, SYSID_ADDR_TS=1'b1, and the default expected constants.
- One natural sub-module: system_0_sysid_rd_timer, which combines the latency counter and the timeout counter with load/expire outputs. Everything else stays in the top-level FSM.

## Test plan
- Matching slave, READ_LATENCY=0, waitrequest=0, ID 0 / TS 1766031671 -> done at start+3, id_ok=1, ts_ok=1, timeout=0, two reads with addresses 0 then 1.
- Slave returns TS 32'h6943_8136 -> id_ok=1, ts_ok=0, ts_value=32'h6943_8136, done pulses once.
- waitrequest high 4 cycles on each read, READ_LATENCY=2 -> address and read held stable during stalls; done at start+3+4+8; both ok.
- waitrequest stuck high, TIMEOUT_CYCLES=16 -> avm_read drops after 16 cycles, timeout=1, id_ok=ts_ok=0, no address-1 read issued.
- start pulsed while busy, then reset_n asserted mid-WAIT_TS -> second start ignored; on reset all outputs 0 immediately; with AUTO_START=1 a fresh check runs after release.

Source files
------------

// File: rtl/system_0_sysid_pkg.sv
// Shared definitions for the system-ID checker: FSM encoding, slave word
// addresses and the build-time expected ID/timestamp defaults.
package system_0_sysid_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ID   = 3'd1,
        WAIT_ID = 3'd2,
        RD_TS   = 3'd3,
        WAIT_TS = 3'd4,
        DONE    = 3'd5
    } sysid_state_t;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    localparam logic [31:0] SYSID_EXPECTED_ID    = 32'h0000_0000;
    localparam logic [31:0] SYSID_EXPECTED_TS    = 32'h6943_8137;
    localparam int          SYSID_READ_LATENCY   = 0;
    localparam int          SYSID_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/system_0_sysid_checker_if.sv
// Avalon-MM read-only master bus between the system-ID checker and its slave.
interface system_0_sysid_checker_if;
    // A read is accepted on a rising edge where avm_read=1 and avm_waitrequest=0;
    // address and read stay stable while waitrequest is high, and readdata is
    // valid READ_LATENCY cycles after acceptance (same edge when latency is 0).
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_waitrequest,
        input  avm_readdata
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_waitrequest,
        output avm_readdata
    );
endinterface

// File: rtl/system_0_sysid_rd_timer.sv
// Read-data latency countdown plus per-transaction timeout counter.
module system_0_sysid_rd_timer #(
    parameter int READ_LATENCY   = 0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clock,
    input  logic reset_n,
    input  logic to_load,
    input  logic to_run,
    input  logic lat_load,
    output logic lat_last,
    output logic expired
);

    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]  LAT_INIT = (READ_LATENCY > 0) ? 3'(READ_LATENCY - 1) : 3'd0;

    logic [15:0] to_cnt;
    logic [2:0]  lat_cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt  <= 16'd0;
            lat_cnt <= 3'd0;
        end else begin
            if (to_load)
                to_cnt <= 16'd0;
            else if (to_run && to_cnt != 16'hFFFF)
                to_cnt <= to_cnt + 16'd1;

            if (lat_load)
                lat_cnt <= LAT_INIT;
            else if (lat_cnt != 3'd0)
                lat_cnt <= lat_cnt - 3'd1;
        end
    end

    // The budget counts cycles from read assertion, so the last legal capture
    // cycle is the one where the counter shows TIMEOUT_CYCLES-1.
    assign lat_last = (lat_cnt == 3'd0);
    assign expired  = to_run && (to_cnt >= TO_LAST);

endmodule

// File: rtl/system_0_sysid_checker.sv
// Boot-time system-ID checker: reads ID and timestamp words over Avalon-MM
// and reports match/mismatch/timeout to the boot sequencer.
module system_0_sysid_checker
    import system_0_sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = SYSID_EXPECTED_ID,
    parameter logic [31:0] EXPECTED_TS    = SYSID_EXPECTED_TS,
    parameter int          READ_LATENCY   = SYSID_READ_LATENCY,
    parameter int          TIMEOUT_CYCLES = SYSID_TIMEOUT_CYCLES,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      start,
    system_0_sysid_checker_if.master  avm,
    output logic                      busy,
    output logic                      done,
    output logic                      id_ok,
    output logic                      ts_ok,
    output logic                      timeout,
    output logic [31:0]               id_value,
    output logic [31:0]               ts_value,
    output sysid_state_t              state_dbg
);

    sysid_state_t state, state_next;
    logic auto_pending;
    logic to_load, to_run, lat_load, lat_last, expired;
    logic cap_id, cap_ts, set_timeout, clr_flags, addr_load, addr_next;

    system_0_sysid_rd_timer #(
        .READ_LATENCY   (READ_LATENCY),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clock    (clock),
        .reset_n  (reset_n),
        .to_load  (to_load),
        .to_run   (to_run),
        .lat_load (lat_load),
        .lat_last (lat_last),
        .expired  (expired)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            auto_pending    <= 1'(AUTO_START);
            avm.avm_address <= SYSID_ADDR_ID;
            id_ok           <= 1'b0;
            ts_ok           <= 1'b0;
            timeout         <= 1'b0;
            id_value        <= 32'd0;
            ts_value        <= 32'd0;
        end else begin
            state <= state_next;
            if (state == IDLE)
                auto_pending <= 1'b0;
            if (addr_load)
                avm.avm_address <= addr_next;
            if (clr_flags) begin
                id_ok   <= 1'b0;
                ts_ok   <= 1'b0;
                timeout <= 1'b0;
            end
            if (set_timeout)
                timeout <= 1'b1;
            if (cap_id) begin
                id_value <= avm.avm_readdata;
                id_ok    <= (avm.avm_readdata == EXPECTED_ID);
            end
            if (cap_ts) begin
                ts_value <= avm.avm_readdata;
                ts_ok    <= (avm.avm_readdata == EXPECTED_TS);
            end
        end
    end

    always_comb begin
        state_next  = state;
        to_load     = 1'b0;
        lat_load    = 1'b0;
        cap_id      = 1'b0;
        cap_ts      = 1'b0;
        set_timeout = 1'b0;
        clr_flags   = 1'b0;
        addr_load   = 1'b0;
        addr_next   = SYSID_ADDR_ID;
        unique case (state)
            IDLE: begin
                if (start || auto_pending) begin
                    clr_flags  = 1'b1;
                    to_load    = 1'b1;
                    addr_load  = 1'b1;
                    addr_next  = SYSID_ADDR_ID;
                    state_next = RD_ID;
                end
            end
            RD_ID, WAIT_ID: begin
                // Capture beats the timeout when both land on the same cycle.
                if ((state == RD_ID && !avm.avm_waitrequest && READ_LATENCY == 0) ||
                    (state == WAIT_ID && lat_last)) begin
                    cap_id     = 1'b1;
                    to_load    = 1'b1;
                    addr_load  = 1'b1;
                    addr_next  = SYSID_ADDR_TS;
                    state_next = RD_TS;
                end else if (state == RD_ID && !avm.avm_waitrequest) begin
                    lat_load   = 1'b1;
                    state_next = WAIT_ID;
                end else if (expired) begin
                    set_timeout = 1'b1;
                    state_next  = DONE;
                end
            end
            RD_TS, WAIT_TS: begin
                if ((state == RD_TS && !avm.avm_waitrequest && READ_LATENCY == 0) ||
                    (state == WAIT_TS && lat_last)) begin
                    cap_ts     = 1'b1;
                    state_next = DONE;
                end else if (state == RD_TS && !avm.avm_waitrequest) begin
                    lat_load   = 1'b1;
                    state_next = WAIT_TS;
                end else if (expired) begin
                    set_timeout = 1'b1;
                    state_next  = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign to_run       = (state == RD_ID) || (state == WAIT_ID) ||
                          (state == RD_TS) || (state == WAIT_TS);
    assign avm.avm_read = (state == RD_ID) || (state == RD_TS);
    assign busy         = (state != IDLE);
    assign done         = (state == DONE);
    assign state_dbg    = state;

endmodule

// File: tb/tb_system_0_sysid_checker.sv
// Directed bench: dut0 has a zero-latency slave, dut1 a two-cycle-latency
// slave with a 16-cycle timeout budget.
module tb_system_0_sysid_checker;
    import system_0_sysid_pkg::*;

    localparam logic [31:0] EXP_ID = 32'h0000_0000;
    localparam logic [31:0] EXP_TS = 32'd1766031671;

    logic clock;
    logic rst0_n, rst1_n, start0, start1, wr0, wr1;
    logic [31:0] id0_word, ts0_word, id1_word, ts1_word;
    logic busy0, done0, id_ok0, ts_ok0, timeout0;
    logic busy1, done1, id_ok1, ts_ok1, timeout1;
    logic [31:0] id_value0, ts_value0, id_value1, ts_value1;
    sysid_state_t st0, st1;
    logic p1, p2;
    int checks, passes;

    system_0_sysid_checker_if if0 ();
    system_0_sysid_checker_if if1 ();

    // Clock and slave models
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    assign if0.avm_waitrequest = wr0;
    assign if0.avm_readdata    = if0.avm_address ? ts0_word : id0_word;

    always @(posedge clock) begin
        p1 <= if1.avm_address;
        p2 <= p1;
    end
    assign if1.avm_waitrequest = wr1;
    assign if1.avm_readdata    = p2 ? ts1_word : id1_word;

    system_0_sysid_checker #(
        .EXPECTED_ID (EXP_ID), .EXPECTED_TS (EXP_TS),
        .READ_LATENCY (0), .TIMEOUT_CYCLES (255), .AUTO_START (1'b1)
    ) dut0 (
        .clock (clock), .reset_n (rst0_n), .start (start0), .avm (if0),
        .busy (busy0), .done (done0), .id_ok (id_ok0), .ts_ok (ts_ok0),
        .timeout (timeout0), .id_value (id_value0), .ts_value (ts_value0),
        .state_dbg (st0)
    );

    system_0_sysid_checker #(
        .EXPECTED_ID (EXP_ID), .EXPECTED_TS (EXP_TS),
        .READ_LATENCY (2), .TIMEOUT_CYCLES (16), .AUTO_START (1'b1)
    ) dut1 (
        .clock (clock), .reset_n (rst1_n), .start (start1), .avm (if1),
        .busy (busy1), .done (done1), .id_ok (id_ok1), .ts_ok (ts_ok1),
        .timeout (timeout1), .id_value (id_value1), .ts_value (ts_value1),
        .state_dbg (st1)
    );

    // Driver tasks
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    endtask

    initial begin
        checks = 0; passes = 0;
        rst0_n = 1'b0; rst1_n = 1'b0; start0 = 1'b0; start1 = 1'b0;
        wr0 = 1'b0; wr1 = 1'b0;
        id0_word = EXP_ID; ts0_word = EXP_TS; id1_word = EXP_ID; ts1_word = EXP_TS;
        #12;

        // Reset state, both instances
        chk("rst0_ctl", 32'({busy0, done0, id_ok0, ts_ok0, timeout0, if0.avm_read, if0.avm_address}), 32'd0);
        chk("rst0_values", id_value0 | ts_value0, 32'd0);
        chk("rst0_state", 32'(st0), 32'(IDLE));
        chk("rst1_ctl", 32'({busy1, done1, id_ok1, ts_ok1, timeout1, if1.avm_read, if1.avm_address}), 32'd0);

        // dut0: auto-start after release, matching slave
        rst0_n = 1'b1;
        tick();
        chk("auto0_rd_id", 32'({if0.avm_read, if0.avm_address, busy0}), 32'b101);
        tick();
        chk("auto0_rd_ts", 32'({if0.avm_read, if0.avm_address, id_ok0}), 32'b111);
        tick();
        chk("auto0_done", 32'({done0, if0.avm_read, id_ok0, ts_ok0, timeout0, busy0}), 32'b101101);
        chk("auto0_ts_value", ts_value0, EXP_TS);
        chk("auto0_id_value", id_value0, EXP_ID);
        tick();
        chk("auto0_idle", 32'({done0, busy0}), 32'd0);

        // dut0: timestamp off by one
        ts0_word = 32'h6943_8136;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        chk("tsbad_flags_cleared", 32'({id_ok0, ts_ok0, timeout0, busy0}), 32'b0001);
        tick();
        tick();
        chk("tsbad_done", 32'({done0, id_ok0, ts_ok0, timeout0}), 32'b1100);
        chk("tsbad_ts_value", ts_value0, 32'h6943_8136);
        tick();
        chk("tsbad_done_once", 32'({done0, busy0}), 32'd0);

        // dut0: ID mismatch, timestamp good
        ts0_word = EXP_TS; id0_word = 32'hDEAD_0001;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        tick();
        tick();
        chk("idbad_done", 32'({done0, id_ok0, ts_ok0}), 32'b101);
        chk("idbad_id_value", id_value0, 32'hDEAD_0001);
        tick();

        // dut1: auto-start with two-cycle read latency
        rst1_n = 1'b1;
        tick();
        chk("auto1_rd_id", 32'({if1.avm_read, if1.avm_address}), 32'b10);
        tick();
        chk("auto1_wait_id", 32'({if1.avm_read, 29'd0, st1}), 32'(WAIT_ID));
        tick();
        tick();
        chk("auto1_rd_ts", 32'({if1.avm_read, if1.avm_address, id_ok1}), 32'b111);
        tick();
        tick();
        tick();
        chk("auto1_done", 32'({done1, id_ok1, ts_ok1, timeout1}), 32'b1110);
        tick();
        chk("auto1_idle", 32'(busy1), 32'd0);

        // dut1: four stall cycles on each read
        wr1 = 1'b1;
        start1 = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            start1 = 1'b0;
            chk("stall_id_hold", 32'({if1.avm_read, if1.avm_address}), 32'b10);
        end
        wr1 = 1'b0;
        tick();
        tick();
        chk("stall_id_wait", 32'({if1.avm_read, if1.avm_address}), 32'b00);
        tick();
        chk("stall_ts_first", 32'({if1.avm_read, if1.avm_address, id_ok1}), 32'b111);
        wr1 = 1'b1;
        for (int i = 9; i <= 12; i++) begin
            tick();
            chk("stall_ts_hold", 32'({if1.avm_read, if1.avm_address}), 32'b11);
        end
        wr1 = 1'b0;
        tick();
        tick();
        chk("stall_ts_wait", 32'({if1.avm_read, if1.avm_address, done1}), 32'b010);
        tick();
        chk("stall_done", 32'({done1, id_ok1, ts_ok1, timeout1}), 32'b1110);
        chk("stall_ts_value", ts_value1, EXP_TS);
        tick();
        chk("stall_idle", 32'({done1, busy1}), 32'd0);

        // dut1: waitrequest stuck high, 16-cycle budget
        wr1 = 1'b1;
        start1 = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            start1 = 1'b0;
            chk("to_read_held", 32'({if1.avm_read, if1.avm_address}), 32'b10);
        end
        tick();
        chk("to_done", 32'({done1, if1.avm_read, timeout1, id_ok1, ts_ok1}), 32'b10100);
        chk("to_no_ts_read", 32'(if1.avm_address), 32'd0);
        wr1 = 1'b0;
        tick();
        chk("to_held", 32'({done1, busy1, timeout1}), 32'b001);

        // dut1: start while busy is ignored, then reset mid-WAIT_TS
        start1 = 1'b1;
        tick();
        chk("busy_rd_id", 32'({if1.avm_read, if1.avm_address, timeout1}), 32'b100);
        tick();
        start1 = 1'b0;
        chk("busy_wait_id", 32'(st1), 32'(WAIT_ID));
        tick();
        tick();
        chk("busy_no_restart", 32'({if1.avm_read, if1.avm_address}), 32'b11);
        tick();
        chk("busy_wait_ts", 32'(st1), 32'(WAIT_TS));
        #2 rst1_n = 1'b0;
        #1;
        chk("midrst_ctl", 32'({busy1, done1, id_ok1, ts_ok1, timeout1, if1.avm_read, if1.avm_address}), 32'd0);
        chk("midrst_values", id_value1 | ts_value1, 32'd0);
        chk("midrst_state", 32'(st1), 32'(IDLE));
        tick();
        tick();
        chk("midrst_quiet", 32'({busy1, if1.avm_read}), 32'd0);
        rst1_n = 1'b1;
        tick();
        chk("rerun_rd_id", 32'({if1.avm_read, if1.avm_address, busy1}), 32'b101);
        for (int i = 2; i <= 7; i++) tick();
        chk("rerun_done", 32'({done1, id_ok1, ts_ok1, timeout1}), 32'b1110);
        tick();
        chk("rerun_idle", 32'({done1, busy1}), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
